// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, constants and round helper functions
package aes_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [79:0] RCON_TBL = 80'h01_02_04_08_10_20_40_80_1b_36;

    // Round constant for rounds 1..10; any other value yields 0.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 10; i++)
            if (rnd == 4'(i + 1)) r = RCON_TBL[79 - 8 * i -: 8];
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Byte k of a block sits at [127-8k -: 8]; state[row][col] = byte[4*col+row].
    function automatic int byte_idx(input int row, input int col);
        return 4 * col + row;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int row, input int col);
        return s[127 - 8 * byte_idx(row, col) -: 8];
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8 * byte_idx(r, c) -: 8] = get_byte(s, r, (c + r) % 4);
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(s, 0, c);
            a1 = get_byte(s, 1, c);
            a2 = get_byte(s, 2, c);
            a3 = get_byte(s, 3, c);
            o[127 - 8 * byte_idx(0, c) -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[127 - 8 * byte_idx(1, c) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[127 - 8 * byte_idx(2, c) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[127 - 8 * byte_idx(3, c) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box; i_byte in, o_byte = S(i_byte) out
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128 encryptor, one round per clock, on-the-fly key expansion
// Ports: clk, rst_n (async active-low); in_valid/in_ready + key, plaintext (accept side);
//        out_valid/out_ready + ciphertext (result side).
// Build option AES_ROUND_DBG_EN adds dbg_round[3:0] and dbg_state[127:0], the round just
// completed and the state it produced, refreshed on every RUN cycle.
module aes_iter_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
`ifdef AES_ROUND_DBG_EN
    ,
    output logic [3:0]   dbg_round,
    output logic [127:0] dbg_state
`endif
);

    fsm_t         r_fsm, w_fsm_nxt;
    logic [127:0] r_state, r_key;
    logic [3:0]   r_round;
    logic [127:0] w_sub, w_sr, w_round_out, w_key_nxt;
    logic [31:0]  w_rot, w_sw, w_t, w_k0, w_k1, w_k2, w_k3;
    logic         w_accept, w_last;

    for (genvar i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sb (.i_byte(r_state[8 * i +: 8]), .o_byte(w_sub[8 * i +: 8]));
    end

    for (genvar i = 0; i < 4; i++) begin : g_kb
        aes_sbox u_kb (.i_byte(w_rot[8 * i +: 8]), .o_byte(w_sw[8 * i +: 8]));
    end

    // Next round key derived from the current one; w3 is the last word of r_key.
    assign w_rot     = {r_key[23:0], r_key[31:24]};
    assign w_t       = w_sw ^ {rcon(r_round), 24'h0};
    assign w_k0      = r_key[127:96] ^ w_t;
    assign w_k1      = r_key[95:64] ^ w_k0;
    assign w_k2      = r_key[63:32] ^ w_k1;
    assign w_k3      = r_key[31:0] ^ w_k2;
    assign w_key_nxt = {w_k0, w_k1, w_k2, w_k3};

    assign w_last      = r_round == 4'd10;
    assign w_sr        = shift_rows(w_sub);
    assign w_round_out = (w_last ? w_sr : mix_columns(w_sr)) ^ w_key_nxt;
    assign w_accept    = in_valid & in_ready;
    assign ciphertext  = r_state;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_fsm <= IDLE;
        else r_fsm <= w_fsm_nxt;

    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_fsm_nxt = RUN;
            end
            RUN:  if (w_last) w_fsm_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_nxt = IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= '0;
            r_key   <= '0;
            r_round <= '0;
        end else if (w_accept) begin
            r_state <= plaintext ^ key;
            r_key   <= key;
            r_round <= 4'd1;
        end else if (r_fsm == RUN) begin
            r_state <= w_round_out;
            r_key   <= w_key_nxt;
            r_round <= w_last ? 4'd0 : r_round + 4'd1;
        end

`ifdef AES_ROUND_DBG_EN
    // Registered alongside the state so dbg_round names the round dbg_state came from.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            dbg_round <= '0;
            dbg_state <= '0;
        end else if (r_fsm == RUN) begin
            dbg_round <= r_round;
            dbg_state <= w_round_out;
        end
`endif

endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: randomized self-checking bench for aes_iter_core against a byte-level AES model
module tb_aes_iter_core;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] plaintext = '0;
    logic         in_ready, out_valid;
    logic [127:0] ciphertext;
`ifdef AES_ROUND_DBG_EN
    logic [3:0]   dbg_round;
    logic [127:0] dbg_state;
    logic [127:0] dbg_r1;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] ref_sb [256];

    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_iter_core dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .key(key), .plaintext(plaintext), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext)
`ifdef AES_ROUND_DBG_EN
        , .dbg_round(dbg_round), .dbg_state(dbg_state)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            ref_sb[x] = b;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [31:0] x;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            x = w[i - 1];
            if (i % 4 == 0) begin
                x = {ref_sb[x[23:16]], ref_sb[x[15:8]], ref_sb[x[7:0]], ref_sb[x[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ x;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = ref_sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) s[4 * c + rw] = t[4 * ((c + rw) % 4) + rw];
            if (r < 10)
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
                    s[4 * c]     = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
                    s[4 * c + 3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
                end
            for (int i = 0; i < 16; i++) s[i] ^= w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drives one block at negedges; samples outputs at negedges (away from the rising edge).
    task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] p,
                             input logic [127:0] exp, input int hold, input bit noise);
        int n;
        bit bad;
        logic [127:0] held;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({tag, "_wait_ready"}, 128'(in_ready), 128'd1);
            return;
        end
        key = k;
        plaintext = p;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = noise;
        bad = 0;
        n = 0;
        while (!out_valid && n < 30) begin
            if (in_ready) bad = 1;
            if (noise) begin
                key = rnd128();
                plaintext = rnd128();
                out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
`ifdef AES_ROUND_DBG_EN
            if (n <= 10) check({tag, "_dbg_round"}, 128'(dbg_round), 128'(n));
            if (n == 1) dbg_r1 = dbg_state;
`endif
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check({tag, "_latency"}, 128'(n), 128'd10);
        check({tag, "_in_ready_during_run"}, 128'(bad), 128'd0);
        check({tag, "_ct"}, ciphertext, exp);
        held = ciphertext;
        bad = 0;
        repeat (hold) begin
            @(negedge clk);
            if (ciphertext !== held || !out_valid || in_ready) bad = 1;
        end
        check({tag, "_hold"}, 128'(bad), 128'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_out_valid_after"}, 128'(out_valid), 128'd0);
        check({tag, "_in_ready_after"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        bit bad;
        logic [127:0] k, p;
        build_sbox();
        #12;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_ct", ciphertext, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd1);

        run_block("fips_b", KB, PB, CB, 0, 0);
`ifdef AES_ROUND_DBG_EN
        check("dbg_state_r1", dbg_r1, 128'ha49c7ff2689f352b6b5bea43026a5049);
`endif
        run_block("fips_c1", KC, PC, CC, 0, 0);
        run_block("backpressure", KB, PB, CB, 5, 0);
        run_block("noise", KB, PB, CB, 2, 1);

        // Abort mid-run: reset around round 5, then nothing may emerge.
        key = KB;
        plaintext = PB;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_ct", ciphertext, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) bad = 1;
        end
        check("abort_no_output", 128'(bad), 128'd0);
        run_block("after_abort", KC, PC, CC, 1, 0);

        for (int i = 0; i < 8; i++) begin
            k = rnd128();
            p = rnd128();
            run_block("random", k, p, aes_ref(k, p), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 Parameters: none; AES-128 only, 10 rounds fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  plaintext and key presented.
REQ-005 in_ready  output  1  core is able to accept a block.
REQ-006 key  input  128  cipher key; byte 0 = key[127:120].
REQ-007 plaintext  input  128  block; byte 0 = [127:120]; state[row][col] = byte[4*col+row].
REQ-008 out_valid  output  1  ciphertext is valid.
REQ-009 out_ready  input  1  consumer accepts the ciphertext.
REQ-010 ciphertext  output  128  result, same byte ordering as plaintext.

Function
REQ-011 FSM states: IDLE, RUN, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 Accept = in_valid & in_ready.
REQ-014 On accept, the state register SHALL load plaintext^key, the round-key register SHALL load key, round counter = 1, and the FSM SHALL go to RUN.
REQ-015 In RUN, each cycle SHALL perform one round: SubBytes, ShiftRows, MixColumns (omitted when round = 10), then AddRoundKey with the next expanded key.
REQ-016 The next expanded key SHALL be computed on the fly from the round-key register using RotWord, SubWord and Rcon[round].
REQ-017 ShiftRows: output row r, column c SHALL take input row r, column (c+r) mod 4.
REQ-018 The round counter SHALL count 1..10. At round 10 the FSM SHALL go to DONE and the counter SHALL return to 0.
REQ-019 Latency: out_valid SHALL rise exactly 10 rising edges after the accepting edge.
REQ-020 ciphertext SHALL be driven from the state register and held stable while out_valid=1 and out_ready=0.
REQ-021 DONE with out_ready=1 SHALL go to IDLE on the next edge.
REQ-022 A new block is accepted no earlier than the cycle after the output handshake; there is no back-to-back overlap.
REQ-023 in_valid, key and plaintext SHALL be ignored outside IDLE; inputs need not be held after accept.
REQ-024 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-025 rst_n low SHALL force: FSM = IDLE, round = 0, state register = 0, round-key register = 0, out_valid = 0, ciphertext = 0.
REQ-026 in_ready SHALL be 1 one cycle after rst_n is released.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the block silently; no partial result is emitted.

Configuration
REQ-028 Macro AES_ROUND_DBG_EN.
- Defined: extra outputs dbg_round[3:0] (the round counter) and dbg_state[127:0] (the state register after each round), both updated every RUN cycle.
- Undefined: those ports are absent; function and latency are identical.

Structure
REQ-029 Shared package aes_pkg SHALL hold:
- the FSM state enum;
- the Rcon table (01,02,04,08,10,20,40,80,1b,36);
- the xtime/GF(2^8) multiply function;
- ShiftRows and MixColumns functions;
- byte/column index helpers.
REQ-030 Sub-module aes_sbox: combinational 8-bit forward S-box. Instantiated 20 times: 16 for the state, 4 for SubWord.

Verification
REQ-031 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, out_valid 10 edges after accept.
REQ-032 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-033 Backpressure: out_ready held 0 for 5 cycles after out_valid -> ciphertext stable, in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-034 Inputs changed during RUN (in_valid=1, random key/pt) -> result is unchanged from REQ-031 and no second accept occurs.
REQ-035 rst_n pulsed low at round 5 -> out_valid never rises; a subsequent REQ-032 vector completes correctly.
REQ-036 With AES_ROUND_DBG_EN defined, REQ-031 vector -> dbg_state after round 1 = a49c7ff2689f352b6b5bea43026a5049 and dbg_round steps 1..10.
